// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode encoding and default widths for the multi-channel PWM.
package pwm_pkg;
    typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_t;
    localparam int DEF_N          = 8;
    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_PRESCALE_W = 16;
endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: prescaler producing a one-clk tick every prescale+1 enabled clocks.
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    localparam logic [PRESCALE_W-1:0] ONE = 1;
    logic [PRESCALE_W-1:0] r_cnt;

    assign tick = ena && (r_cnt == prescale);

    always_ff @(posedge clk) begin
        if (!rst)
            r_cnt <= '0;
        else
            r_cnt <= (!ena || tick) ? '0 : r_cnt + ONE;
    end
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: shared edge/center-aligned counter driving CHANNELS PWM outputs
// with double-buffered duty, period and mode that swap at period boundaries.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [N-1:0]          period,
    input  logic                  mode,
    input  logic [CHANNELS*N-1:0] duty,
    input  logic [CHANNELS-1:0]   duty_wr,
    input  logic [CHANNELS-1:0]   polarity,
    output logic [CHANNELS-1:0]   out,
    output logic                  period_end
);
    localparam logic [N-1:0] ONE = 1;

    logic      w_tick;
    logic      [N-1:0] r_cnt, w_cnt_nxt, r_period;
    logic      r_down, w_down_nxt;
    logic      w_bnd, w_load;
    pwm_mode_t r_mode;
    logic      r_period_end;

    pwm_tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .prescale (prescale),
        .tick     (w_tick)
    );

    // The >= compare keeps edge mode wrapping at the latched P even if the input P shrank.
    always_comb begin
        w_cnt_nxt  = (r_mode == PWM_EDGE) ? ((r_cnt >= r_period) ? '0 : r_cnt + ONE) :
                     (r_period == '0) ? '0 :
                     (!r_down && r_cnt < r_period) ? r_cnt + ONE : r_cnt - ONE;
        w_down_nxt = (w_cnt_nxt == '0) ? 1'b0 :
                     (r_mode == PWM_CENTER && r_cnt >= r_period) ? 1'b1 : r_down;
        w_bnd      = w_tick && (w_cnt_nxt == '0);
        w_load     = !ena || w_bnd;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_down       <= 1'b0;
            r_period     <= '1;
            r_mode       <= PWM_EDGE;
            r_period_end <= 1'b0;
        end else begin
            r_cnt        <= !ena ? '0 : w_tick ? w_cnt_nxt : r_cnt;
            r_down       <= !ena ? 1'b0 : w_tick ? w_down_nxt : r_down;
            r_period_end <= w_bnd;
            if (w_load) begin
                r_period <= period;
                r_mode   <= pwm_mode_t'(mode);
            end
        end
    end

    assign period_end = r_period_end;

    for (genvar g = 0; g < CHANNELS; g++) begin : ch
        logic [N-1:0] r_pend, r_act, w_pend_nxt;
        logic         w_cmp, r_o;

        // A write in a load cycle passes straight through to the active duty.
        always_comb begin
            w_pend_nxt = duty_wr[g] ? duty[g*N +: N] : r_pend;
            w_cmp      = r_cnt < r_act;
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_pend <= '0;
                r_act  <= '0;
                r_o    <= 1'b0;
            end else begin
                r_pend <= w_pend_nxt;
                r_o    <= ena ? (w_cmp ^ polarity[g]) : polarity[g];
                if (w_load)
                    r_act <= w_pend_nxt;
            end
        end

        assign out[g] = r_o;
    end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: randomized and directed stimulus against a phase-index reference
// model; expected outputs are queued per edge and checked by a separate monitor.
module tb_pwm_multi;
    localparam int N  = 8;
    localparam int CH = 4;
    localparam int PW = 16;

    logic          clk = 0, rst = 0, ena = 0, mode = 0;
    logic [PW-1:0] prescale = '0;
    logic [N-1:0]  period = '0;
    logic [CH*N-1:0] duty = '0;
    logic [CH-1:0] duty_wr = '0, polarity = '0, out;
    logic          period_end;

    always #5 clk = ~clk;

    pwm_multi #(.N(N), .CHANNELS(CH), .PRESCALE_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .prescale   (prescale),
        .period     (period),
        .mode       (mode),
        .duty       (duty),
        .duty_wr    (duty_wr),
        .polarity   (polarity),
        .out        (out),
        .period_end (period_end)
    );

    typedef struct packed {
        logic [CH-1:0] o;
        logic          pe;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Model keeps the position within the period; counter value is derived from it.
    int   m_ps, m_k, m_P;
    logic m_mode;
    int   m_pend[CH], m_act[CH];

    function automatic int plen();
        return m_mode ? ((m_P == 0) ? 1 : 2 * m_P) : m_P + 1;
    endfunction

    function automatic int ctr();
        return (!m_mode || m_k <= m_P) ? m_k : 2 * m_P - m_k;
    endfunction

    initial forever begin
        exp_t e;
        int   c;
        logic t, b;
        @(posedge clk);
        e = '0;
        if (!rst) begin
            m_ps = 0; m_k = 0; m_P = 255; m_mode = 1'b0;
            for (int i = 0; i < CH; i++) begin
                m_pend[i] = 0;
                m_act[i]  = 0;
            end
        end else begin
            c = ctr();
            for (int i = 0; i < CH; i++)
                e.o[i] = ena ? ((c < m_act[i]) ^ polarity[i]) : polarity[i];
            t    = ena && (m_ps == int'(prescale));
            b    = t && ((m_k + 1) % plen() == 0);
            e.pe = b;
            for (int i = 0; i < CH; i++)
                if (duty_wr[i]) m_pend[i] = int'(duty[i*N +: N]);
            m_ps = (!ena || t) ? 0 : m_ps + 1;
            m_k  = !ena ? 0 : t ? (m_k + 1) % plen() : m_k;
            if (!ena || b) begin
                m_P    = int'(period);
                m_mode = mode;
                for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
            end
        end
        sb.push_back(e);
    end

    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty t=%0t: no expected entry queued", $time);
        end else begin
            e = sb.pop_front();
            if ({out, period_end} !== {e.o, e.pe}) begin
                errors++;
                $display("FAIL out_pe t=%0t got out=%b pe=%b exp out=%b pe=%b",
                         $time, out, period_end, e.o, e.pe);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int c, input int v);
        duty[c*N +: N] = N'(v);
        duty_wr[c] = 1'b1;
        @(negedge clk);
        duty_wr[c] = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        cyc(2);
        rst = 1;
        // edge P=9 duty0=3
        prescale = 0; mode = 0; period = 9;
        wr(0, 3);
        ena = 1;
        cyc(35);
        // duty 0 and duty > P
        ena = 0;
        wr(0, 0);
        wr(1, 10);
        ena = 1;
        cyc(35);
        // center P=4 prescale=1
        ena = 0; mode = 1; period = 4; prescale = 1;
        wr(0, 2);
        ena = 1;
        cyc(40);
        // duty update mid-period and at assorted offsets incl. boundary
        ena = 0; mode = 0; period = 9; prescale = 0;
        wr(0, 5);
        ena = 1;
        cyc(3);
        wr(0, 2);
        cyc(25);
        for (int i = 0; i < 12; i++) begin
            wr(0, i % 7);
            cyc(i % 3);
        end
        // polarity with ena low then duty 0
        ena = 0; polarity = 4'b0100;
        wr(2, 0);
        cyc(3);
        ena = 1;
        cyc(12);
        // reset mid-period
        cyc(4);
        rst = 0;
        @(negedge clk);
        rst = 1;
        cyc(15);
        // randomized traffic
        for (int it = 0; it < 600; it++) begin
            if (!ena) prescale = PW'($urandom_range(3));
            if ($urandom_range(40) == 0) ena = ~ena;
            if ($urandom_range(4) == 0) period = N'($urandom_range(12));
            if ($urandom_range(6) == 0) mode = 1'($urandom_range(1));
            if ($urandom_range(20) == 0) polarity = CH'($urandom);
            rst = ($urandom_range(80) != 0);
            for (int c = 0; c < CH; c++) begin
                duty_wr[c] = ($urandom_range(5) == 0);
                duty[c*N +: N] = N'($urandom_range(14));
            end
            @(negedge clk);
        end
        duty_wr = '0; rst = 1; ena = 0;
        cyc(3);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
